// File: rtl/sum_accumulator_pkg.sv
// Shared definitions for the sum accumulator: FSM encoding, default widths and a
// constant-evaluable ceiling log2.
package sum_accumulator_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam int ADD_IN_W  = 9;
    localparam int ADD_ACC_W = 13;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sum_accumulator_add_nbit.sv
// W-bit ripple-carry adder built from full-adder cells, carry-in tied low.
// Purely combinational; the carry out is exposed so callers can ignore it explicitly.
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module add_nbit #(
    parameter int W = 13
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_bit
        fa u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    assign cout = carry[W];
endmodule

// File: rtl/sum_accumulator.sv
// Accumulates NUM_TERMS input sums per frame and presents the total one cycle after the last beat;
// while a total is pending (HOLD) in_ready is low, and in ACCUM clear drops in_ready and the partial total.
module sum_accumulator
    import sum_accumulator_pkg::*;
#(
    parameter int IN_W      = ADD_IN_W,
    parameter int NUM_TERMS = 16,
    parameter int ACC_W     = ADD_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_data,
    input  logic             out_ready,
    output logic             busy
);
    localparam int CNT_W = clog2(NUM_TERMS);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] addend;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic             beat;
    logic             last;
    logic             unused_co;

    assign in_ready = (state == ST_ACCUM) && !clear;
    assign beat     = in_valid && in_ready;
    assign last     = (cnt == CNT_W'(NUM_TERMS - 1));
    assign busy     = (cnt != '0) || out_valid;

    // Gate the addend so an undriven in_data between beats never reaches the adder.
    assign addend = beat ? {{(ACC_W - IN_W){1'b0}}, in_data} : '0;

    add_nbit #(.W(ACC_W)) u_add (
        .a    (acc),
        .b    (addend),
        .sum  (sum),
        .cout (unused_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_ACCUM;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (clear) begin
                        acc <= '0;
                        cnt <= '0;
                    end else if (beat) begin
                        if (last) begin
                            out_data  <= sum;
                            out_valid <= 1'b1;
                            acc       <= '0;
                            cnt       <= '0;
                            state     <= ST_HOLD;
                        end else begin
                            acc <= sum;
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_ACCUM;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: frame totals go through a scoreboard queue,
// handshake-level behaviour is checked at fixed points in the sequence.
module tb_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [8:0]  in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [12:0] out_data;
    logic        out_ready = 1'b0;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int model_acc = 0;
    int model_cnt = 0;
    int exp_q[$];

    sum_accumulator #(.IN_W(9), .NUM_TERMS(16), .ACC_W(13)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Present one beat and hold it until accepted; the model only counts accepted beats.
    task automatic send(input logic [8:0] d);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        #1;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            chk("send_timeout", in_ready, 1);
        end else begin
            model_acc += d;
            model_cnt++;
            if (model_cnt == 16) begin
                exp_q.push_back(model_acc);
                model_acc = 0;
                model_cnt = 0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 'x;
    endtask

    // Scoreboard: every output handshake must match the oldest expected total.
    always @(negedge clk) begin
        #2;
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_total", out_valid, 0);
            end else begin
                chk("frame_total", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1. asynchronous reset with no clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);

        // 2. full frame of 510, out_ready high
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(9'd510);
        chk("full_valid_latency", out_valid, 1);
        chk("full_data", out_data, 8160);
        @(negedge clk);
        chk("full_valid_one_cycle", out_valid, 0);

        // 3. backpressure, including a clear during HOLD
        out_ready = 1'b0;
        for (int i = 1; i <= 16; i++) send(9'(i));
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 9'd99;
            clear    = (i == 2);
            #1;
            chk("hold_in_ready", in_ready, 0);
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, 136);
            chk("hold_busy", busy, 1);
            @(negedge clk);
        end
        clear    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("after_hs_valid", out_valid, 0);
        chk("after_hs_in_ready", in_ready, 1);

        // 4. clear mid-frame drops the partial total and blocks that beat
        for (int i = 0; i < 5; i++) send(9'd100);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 9'd7;
        #1;
        chk("clear_in_ready", in_ready, 0);
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        model_acc = 0;
        model_cnt = 0;
        #1;
        chk("clear_busy", busy, 0);
        for (int i = 0; i < 16; i++) send(9'd1);
        @(negedge clk);

        // 5. reset mid-frame
        for (int i = 0; i < 10; i++) send(9'd255);
        #3 rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", out_valid, 0);
        model_acc = 0;
        model_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) send(9'd2);
        chk("midrst_data", out_data, 32);
        @(negedge clk);

        // 6. gapped input, busy tracking
        #1;
        chk("gap_busy_idle", busy, 0);
        for (int i = 0; i < 16; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                if (i > 0) chk("gap_busy_mid", busy, 1);
                @(negedge clk);
            end
            send(9'd300);
        end
        chk("gap_busy_pending", busy, 1);
        chk("gap_data", out_data, 4800);
        @(negedge clk);
        #1;
        chk("gap_busy_done", busy, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
